alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised RV ALU with a valid/ready handshake.
- Base integer ops (RV32I/RV64I funct3 set) complete in 1 cycle, registered.
- Optional M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) run on an iterative radix-2 unit.
- Sits in the execute stage and replaces the combinational alu so the core can stall on multi-cycle ops.

Parameters:
- XLEN, 32, datapath width; must be 32 or 64.
- MULDIV, 1, 1 = M-extension present; 0 = funct7_0 ignored and all ops are base ops.
- SHW, $clog2(XLEN), shift-amount width: the low SHW bits of in_b are used.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request this cycle.
- in_a  in  XLEN  operand A.
- in_b  in  XLEN  operand B (register or immediate).
- funct3  in  3  operation select.
- funct7_4  in  1  instr[30]: SUB/SRA select.
- funct7_0  in  1  instr[25]: M-extension select.
- alu_en  in  1  0 = force ADD regardless of funct fields.
- alu_imm  in  1  1 = immediate form.
- flush  in  1  synchronous abort.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- alu_out  out  XLEN  result.
- busy  out  1  multi-cycle op in progress.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, alu_out=0, busy=0, internal counter/accumulators=0. in_ready is 1 once reset releases.
- Handshake:
  - Accept when in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready), so a new op may be accepted in the same cycle the previous result is consumed.
  - out_valid and alu_out hold stable until out_ready=1.
- Decode:
  - alu_en=0 → ADD.
  - alu_imm=1: funct7_4 is ignored except for funct3=5 (SRAI); funct7_0 is ignored.
  - M-op = MULDIV && funct7_0 && !alu_imm && alu_en.
- Base ops, funct3 0..7 = ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND.
  - SLT/SLTU return zero-extended 0/1.
  - Shifts use in_b[SHW-1:0].
  - Latency: out_valid=1 on the edge after acceptance.
- States: IDLE, MUL, DIV, DONE.
  - IDLE → MUL on an accepted funct3<4 M-op; IDLE → DIV on an accepted funct3>=4 M-op; otherwise the result is registered directly and the state stays IDLE.
  - MUL/DIV: counter runs XLEN cycles, then → DONE.
  - DONE: sign fix-up is applied, out_valid=1, → IDLE.
  - Total latency of an M-op: XLEN+2 cycles from acceptance to out_valid. busy=1 in MUL, DIV and DONE.
- Multiply:
  - Operands are converted to magnitudes per the signedness of the variant: MULH s×s, MULHSU s×u, MULHU u×u, MUL low half.
  - 2*XLEN shift-add accumulator; negate at DONE if the sign differs.
  - MUL returns the low XLEN bits; the MULH* ops return the high XLEN bits.
- Divide: restoring, one quotient bit per cycle on magnitudes. The quotient sign is signA^signB; the remainder sign is signA.
- Divide corner cases, detected at acceptance; the unit still takes the full latency so timing is constant:
  - Divisor 0: DIV/DIVU → all ones; REM/REMU → in_a.
  - Signed overflow (in_a = most-negative, in_b = −1): DIV → in_a; REM → 0.
- flush:
  - Returns to IDLE and clears out_valid and busy next edge.
  - A request presented with flush=1 is not accepted.
  - flush has priority over every other transition.
- Reset mid-operation: the async clear above applies; no partial result is ever emitted.
- Result is held while out_ready=0: DONE does not re-enter IDLE acceptance until the output is consumed, per the in_ready rule.

Decomposition:
- Shared header alu_defs.vh holds:
  - funct3 codes: F3_ADD..F3_AND, F3_MUL..F3_REMU.
  - State encodings ST_IDLE/ST_MUL/ST_DIV/ST_DONE.
- Sub-module alu_muldiv (parametrised by XLEN) holds the iterative multiply/divide engine, counter and corner-case logic.
- alu_seq holds base ops, decode, handshake and output register.

Test Plan:
- Base ADD/SUB/SLT, XLEN=32, out_ready=1:
  - ADD 0xFFFFFFFF+1 → 0x00000000; SUB 3−7 → 0xFFFFFFFC; SLT 0xFFFFFFFF vs 0x7FFFFFFF → 1.
  - Each result must arrive exactly 1 cycle after acceptance, back-to-back with no bubbles.
- Shifts and immediate form:
  - SRAI 0x80000001 by 30 (funct7_4=1, alu_imm=1) → 0xFFFFFFFE.
  - SUB encoding with alu_imm=1 → ADD.
  - alu_en=0, funct3=7 on 3,7 → 10.
- Multiply:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
  - MUL 7×−3 → 0xFFFFFFEB.
  - Each result must arrive 34 cycles after acceptance with busy=1 throughout.
- Divide corners:
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
  - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after a result: alu_out stable, in_ready=0.
  - Raise out_ready together with a new in_valid: the new op is accepted in that same cycle.
- Abort:
  - Assert flush at cycle 10 of a DIV: no out_valid; in_ready=1 the next cycle.
  - Repeat with rst_n pulsed low mid-MUL: outputs are 0 immediately (asynchronously), then normal operation resumes.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - funct3 codes and muldiv state encoding shared by the ALU files
package alu_seq_pkg;

  localparam logic [2:0] F3_ADD    = 3'd0;
  localparam logic [2:0] F3_SLL    = 3'd1;
  localparam logic [2:0] F3_SLT    = 3'd2;
  localparam logic [2:0] F3_SLTU   = 3'd3;
  localparam logic [2:0] F3_XOR    = 3'd4;
  localparam logic [2:0] F3_SR     = 3'd5;
  localparam logic [2:0] F3_OR     = 3'd6;
  localparam logic [2:0] F3_AND    = 3'd7;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // DIV and REM are the signed divide variants (funct3[0] clear).
  function automatic logic div_signed(input logic [2:0] f3);
    return !f3[0];
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - iterative radix-2 multiply / restoring divide engine
module alu_muldiv
  import alu_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [2:0]          op_q;
  logic                neg_q;
  logic                sa_q;
  logic                corner_q;
  logic [XLEN-1:0]     corner_val_q;
  logic [2*XLEN-1:0]   acc;
  logic [2*XLEN-1:0]   mcand;
  logic [XLEN-1:0]     lo;
  logic [XLEN-1:0]     rem;

  logic                sa;
  logic                sb;
  logic [XLEN-1:0]     mag_a;
  logic [XLEN-1:0]     mag_b;
  logic                div0;
  logic                ovf;
  logic [XLEN-1:0]     corner_val;
  logic                last;
  logic [XLEN:0]       r_shift;
  logic [XLEN+1:0]     diff;
  logic                borrow;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quo_fix;
  logic [XLEN-1:0]     rem_fix;

  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    if (op[2]) begin
      sa = a[XLEN-1] && div_signed(op);
      sb = b[XLEN-1] && div_signed(op);
    end else begin
      sa = a[XLEN-1] && (op == F3_MULH || op == F3_MULHSU);
      sb = b[XLEN-1] && (op == F3_MULH);
    end
    mag_a = sa ? -a : a;
    mag_b = sb ? -b : b;
    div0  = (b == '0);
    ovf   = div_signed(op) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    corner_val = '0;
    if (div0)
      corner_val = op[1] ? a : '1;
    else if (ovf)
      corner_val = op[1] ? '0 : a;
  end

  assign last    = (cnt == CW'(XLEN-1));
  assign r_shift = {rem, lo[XLEN-1]};
  assign diff    = {1'b0, r_shift} - {2'b00, mcand[XLEN-1:0]};
  assign borrow  = diff[XLEN+1];

  // Signs are restored only once the magnitude iteration has finished.
  assign prod    = neg_q ? -acc : acc;
  assign quo_fix = neg_q ? -lo : lo;
  assign rem_fix = sa_q ? -rem : rem;

  always_comb begin
    result = '0;
    if (op_q[2])
      result = corner_q ? corner_val_q : (op_q[1] ? rem_fix : quo_fix);
    else
      result = (op_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      op_q         <= '0;
      neg_q        <= 1'b0;
      sa_q         <= 1'b0;
      corner_q     <= 1'b0;
      corner_val_q <= '0;
      acc          <= '0;
      mcand        <= '0;
      lo           <= '0;
      rem          <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= op[2] ? ST_DIV : ST_MUL;
            cnt          <= '0;
            op_q         <= op;
            neg_q        <= sa ^ sb;
            sa_q         <= sa;
            corner_q     <= op[2] && (div0 || ovf);
            corner_val_q <= corner_val;
            acc          <= '0;
            rem          <= '0;
            // mcand carries the multiplicand for MUL and the divisor for DIV.
            mcand        <= {{XLEN{1'b0}}, (op[2] ? mag_b : mag_a)};
            lo           <= op[2] ? mag_a : mag_b;
          end
        end
        ST_MUL: begin
          if (lo[0])
            acc <= acc + mcand;
          mcand <= mcand << 1;
          lo    <= lo >> 1;
          cnt   <= cnt + 1'b1;
          if (last)
            state <= ST_DONE;
        end
        ST_DIV: begin
          rem   <= borrow ? r_shift[XLEN-1:0] : diff[XLEN-1:0];
          lo    <= {lo[XLEN-2:0], !borrow};
          cnt   <= cnt + 1'b1;
          if (last)
            state <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - execute-stage ALU with handshake, 1-cycle base ops and iterative M ops
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit MULDIV = 1'b1,
  parameter int SHW    = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [2:0]      funct3,
  input  logic            funct7_4,
  input  logic            funct7_0,
  input  logic            alu_en,
  input  logic            alu_imm,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_out,
  output logic            busy
);

  logic            is_m;
  logic            alt;
  logic            accept;
  logic [2:0]      op;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] base_res;
  logic            md_busy;
  logic            md_done;
  logic [XLEN-1:0] md_result;

  assign is_m  = MULDIV && funct7_0 && !alu_imm && alu_en;
  assign op    = alu_en ? funct3 : F3_ADD;
  // In immediate form instr[30] only matters for SRAI.
  assign alt   = alu_en && funct7_4 && (!alu_imm || funct3 == F3_SR);
  assign shamt = in_b[SHW-1:0];

  assign in_ready = !md_busy && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready && !flush;
  assign busy     = md_busy;

  always_comb begin
    base_res = '0;
    case (op)
      F3_ADD:  base_res = alt ? (in_a - in_b) : (in_a + in_b);
      F3_SLL:  base_res = in_a << shamt;
      F3_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      F3_SLTU: base_res = {{(XLEN-1){1'b0}}, (in_a < in_b)};
      F3_XOR:  base_res = in_a ^ in_b;
      F3_SR:   base_res = alt ? XLEN'($signed(in_a) >>> shamt) : (in_a >> shamt);
      F3_OR:   base_res = in_a | in_b;
      F3_AND:  base_res = in_a & in_b;
      default: base_res = '0;
    endcase
  end

  alu_muldiv #(
    .XLEN (XLEN)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && is_m),
    .flush  (flush),
    .op     (funct3),
    .a      (in_a),
    .b      (in_b),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  // The engine only starts when no result is pending, so DONE never collides
  // with a held output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alu_out   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (md_done) begin
      out_valid <= 1'b1;
      alu_out   <= md_result;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (accept && !is_m) begin
        out_valid <= 1'b1;
        alu_out   <= base_res;
      end
    end
  end

endmodule
